// File: rtl/uart_pkg.sv
// Shared types for the buffered UART core: TX/RX state encodings and line idle level.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } rx_state_e;

  // Serial line level between frames (mark).
  localparam logic UART_IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_sfifo.sv
// Synchronous show-ahead FIFO. The head entry is visible on rdata_o whenever
// empty_o is low. A push into a full FIFO is accepted only if a pop happens in
// the same cycle (the freed slot is the one being written).
`timescale 1ns/1ps
module uart_sfifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push;
  logic         do_pop;

  // Extra MSB distinguishes full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; both wrap naturally modulo 2*DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array, no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_fifo_core.sv
// Buffered UART transceiver: TX/RX shift engines with runtime baud divider,
// 1/2 stop bits and TX/RX FIFOs. Optional parity bit when UART_PARITY_EN is
// defined (adds cfg_par_en, cfg_par_odd, rx_perr). Divider, stop-bit count and
// parity settings are captured when a frame starts.
`timescale 1ns/1ps
module uart_fifo_core
  import uart_pkg::*;
#(
  parameter int DW       = 8,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int DIV_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_stop2,
`ifdef UART_PARITY_EN
  input  logic             cfg_par_en,
  input  logic             cfg_par_odd,
  output logic             rx_perr,
`endif
  input  logic [DW-1:0]    tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [DW-1:0]    rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_ferr,
  output logic             rx_ovf,
  input  logic             rx_ovf_clr,
  output logic             tx_busy,
  output logic             uart_tx,
  input  logic             uart_rx
);

  localparam int IW = $clog2(DW);
  localparam logic [IW-1:0] LAST_IDX = IW'(DW - 1);
`ifdef UART_PARITY_EN
  localparam int RXW = DW + 2;
`else
  localparam int RXW = DW + 1;
`endif

  // ---------------- TX path ----------------
  logic          tx_fifo_full, tx_fifo_empty, tx_pop;
  logic [DW-1:0] tx_fifo_data;

  uart_sfifo #(.W(DW), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_valid & tx_ready),
    .wdata_i (tx_data),
    .pop_i   (tx_pop),
    .rdata_o (tx_fifo_data),
    .full_o  (tx_fifo_full),
    .empty_o (tx_fifo_empty)
  );

  tx_state_e        tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [DW-1:0]    tx_shift_q, tx_shift_d;
  logic [IW-1:0]    tx_idx_q, tx_idx_d;
  logic             tx_stop2_q, tx_stop2_d, tx_second_q, tx_second_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_par_en_q, tx_par_en_d, tx_par_bit_q, tx_par_bit_d;
  logic             tx_go, tx_bit_end, tx_launch;

  assign tx_ready   = ~tx_fifo_full;
  assign tx_busy    = (tx_state_q != TX_IDLE) | ~tx_fifo_empty;
  assign uart_tx    = tx_line_q;
  assign tx_bit_end = (tx_cnt_q == tx_div_q);
  assign tx_launch  = cfg_en & ~tx_fifo_empty;

  // TX next state: one bit period per state step; a new frame can start
  // straight out of STOP so consecutive frames have no idle gap.
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_cnt_d     = tx_cnt_q + 1'b1;
    tx_div_d     = tx_div_q;
    tx_shift_d   = tx_shift_q;
    tx_idx_d     = tx_idx_q;
    tx_stop2_d   = tx_stop2_q;
    tx_second_d  = tx_second_q;
    tx_line_d    = tx_line_q;
    tx_par_en_d  = tx_par_en_q;
    tx_par_bit_d = tx_par_bit_q;
    tx_go        = 1'b0;
    tx_pop       = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d  = '0;
        tx_line_d = UART_IDLE_LVL;
        tx_go     = tx_launch;
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
          tx_idx_d   = '0;
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = tx_shift_q >> 1;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_idx_q == LAST_IDX) begin
            tx_second_d = 1'b0;
            if (tx_par_en_q) begin
              tx_state_d = TX_PAR;
              tx_line_d  = tx_par_bit_q;
            end else begin
              tx_state_d = TX_STOP;
              tx_line_d  = 1'b1;
            end
          end else begin
            tx_idx_d   = tx_idx_q + 1'b1;
            tx_line_d  = tx_shift_q[0];
            tx_shift_d = tx_shift_q >> 1;
          end
        end
      end
      TX_PAR: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
          tx_line_d  = 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_stop2_q && !tx_second_q) begin
            tx_second_d = 1'b1;
          end else if (tx_launch) begin
            tx_go = 1'b1;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_line_d  = UART_IDLE_LVL;
      end
    endcase
    // Frame launch: pop the head and capture per-frame configuration.
    if (tx_go) begin
      tx_pop     = 1'b1;
      tx_state_d = TX_START;
      tx_cnt_d   = '0;
      tx_line_d  = 1'b0;
      tx_div_d   = cfg_div;
      tx_stop2_d = cfg_stop2;
      tx_shift_d = tx_fifo_data;
`ifdef UART_PARITY_EN
      tx_par_en_d  = cfg_par_en;
      tx_par_bit_d = (^tx_fifo_data) ^ cfg_par_odd;
`else
      tx_par_en_d  = 1'b0;
      tx_par_bit_d = 1'b0;
`endif
    end
  end

  // TX registers; reset forces the line high immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_div_q     <= '0;
      tx_shift_q   <= '0;
      tx_idx_q     <= '0;
      tx_stop2_q   <= 1'b0;
      tx_second_q  <= 1'b0;
      tx_line_q    <= UART_IDLE_LVL;
      tx_par_en_q  <= 1'b0;
      tx_par_bit_q <= 1'b0;
    end else begin
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_div_q     <= tx_div_d;
      tx_shift_q   <= tx_shift_d;
      tx_idx_q     <= tx_idx_d;
      tx_stop2_q   <= tx_stop2_d;
      tx_second_q  <= tx_second_d;
      tx_line_q    <= tx_line_d;
      tx_par_en_q  <= tx_par_en_d;
      tx_par_bit_q <= tx_par_bit_d;
    end
  end

  // ---------------- RX path ----------------
  logic             rx_s1_q, rx_s2_q, rx_prev_q;
  logic             rx_line, rx_fall;
  rx_state_e        rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [DW-1:0]    rx_shift_q, rx_shift_d;
  logic [IW-1:0]    rx_idx_q, rx_idx_d;
  logic             rx_wait_q, rx_wait_d;
  logic             rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d;
  logic             rx_perr_q, rx_perr_d;
  logic             rx_push, rx_pop, rx_full, rx_empty, rx_drop;
  logic             rx_ovf_q, rx_ovf_d;
  logic [RXW-1:0]   rx_wdata, rx_head;

  assign rx_line = rx_s2_q;
  assign rx_fall = rx_prev_q & ~rx_s2_q;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q   <= UART_IDLE_LVL;
      rx_s2_q   <= UART_IDLE_LVL;
      rx_prev_q <= UART_IDLE_LVL;
    end else begin
      rx_s1_q   <= uart_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // RX next state: half-bit wait validates the start bit, then sample mid-bit.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q + 1'b1;
    rx_div_d     = rx_div_q;
    rx_shift_d   = rx_shift_q;
    rx_idx_d     = rx_idx_q;
    rx_wait_d    = rx_wait_q;
    rx_par_en_d  = rx_par_en_q;
    rx_par_odd_d = rx_par_odd_q;
    rx_perr_d    = rx_perr_q;
    rx_push      = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (cfg_en && rx_fall) begin
          rx_state_d = RX_START;
          rx_div_d   = cfg_div;
          rx_perr_d  = 1'b0;
`ifdef UART_PARITY_EN
          rx_par_en_d  = cfg_par_en;
          rx_par_odd_d = cfg_par_odd;
`else
          rx_par_en_d  = 1'b0;
          rx_par_odd_d = 1'b0;
`endif
        end
      end
      RX_START: begin
        if (rx_cnt_q == (rx_div_q >> 1)) begin
          rx_cnt_d = '0;
          rx_idx_d = '0;
          rx_state_d = rx_line ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == rx_div_q) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_line, rx_shift_q[DW-1:1]};
          if (rx_idx_q == LAST_IDX) begin
            rx_wait_d  = 1'b0;
            rx_state_d = rx_par_en_q ? RX_PAR : RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end
      end
      RX_PAR: begin
        if (rx_cnt_q == rx_div_q) begin
          rx_cnt_d   = '0;
          rx_perr_d  = rx_line ^ (^rx_shift_q) ^ rx_par_odd_q;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_wait_q) begin
          // Broken stop bit: hold off until the line returns to mark.
          if (rx_line) begin
            rx_wait_d  = 1'b0;
            rx_state_d = RX_IDLE;
          end
        end else if (rx_cnt_q == rx_div_q) begin
          rx_cnt_d = '0;
          rx_push  = 1'b1;
          if (rx_line) rx_state_d = RX_IDLE;
          else         rx_wait_d  = 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // RX registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_div_q     <= '0;
      rx_shift_q   <= '0;
      rx_idx_q     <= '0;
      rx_wait_q    <= 1'b0;
      rx_par_en_q  <= 1'b0;
      rx_par_odd_q <= 1'b0;
      rx_perr_q    <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_div_q     <= rx_div_d;
      rx_shift_q   <= rx_shift_d;
      rx_idx_q     <= rx_idx_d;
      rx_wait_q    <= rx_wait_d;
      rx_par_en_q  <= rx_par_en_d;
      rx_par_odd_q <= rx_par_odd_d;
      rx_perr_q    <= rx_perr_d;
    end
  end

  // Frame error is the sampled stop level at push time, stored with the data.
`ifdef UART_PARITY_EN
  assign rx_wdata = {rx_perr_q, ~rx_line, rx_shift_q};
  assign rx_perr  = rx_head[DW+1];
`else
  assign rx_wdata = {~rx_line, rx_shift_q};
`endif

  uart_sfifo #(.W(RXW), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .wdata_i (rx_wdata),
    .pop_i   (rx_pop),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  assign rx_valid = ~rx_empty;
  assign rx_pop   = rx_valid & rx_ready;
  assign rx_data  = rx_head[DW-1:0];
  assign rx_ferr  = rx_head[DW];
  assign rx_drop  = rx_push & rx_full & ~rx_pop;
  assign rx_ovf   = rx_ovf_q;

  // Sticky overflow; a new drop wins over a simultaneous clear.
  always_comb begin
    rx_ovf_d = rx_drop | (rx_ovf_q & ~rx_ovf_clr);
  end

  // Overflow flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_ovf_q <= 1'b0;
    else     rx_ovf_q <= rx_ovf_d;
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Directed testbench for uart_fifo_core: reset values, TX waveform, loopback,
// RX overflow, frame error, glitch rejection, mid-frame reset and (with
// UART_PARITY_EN) parity generation/checking.
`timescale 1ns/1ps
module tb_uart_fifo_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_en = 1'b1;
  logic [15:0] cfg_div = 16'd9;
  logic        cfg_stop2 = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        rx_ferr;
  logic        rx_ovf;
  logic        rx_ovf_clr = 1'b0;
  logic        tx_busy;
  logic        uart_tx;
  logic        uart_rx;
  logic        loop = 1'b0;
  logic        rx_drv = 1'b1;
`ifdef UART_PARITY_EN
  logic        cfg_par_en = 1'b0;
  logic        cfg_par_odd = 1'b0;
  logic        rx_perr;
`endif

  int checks = 0;
  int errors = 0;

  assign uart_rx = loop ? uart_tx : rx_drv;

  always #5 clk = ~clk;

  uart_fifo_core #(.DW(8), .TX_DEPTH(8), .RX_DEPTH(8), .DIV_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_en     (cfg_en),
    .cfg_div    (cfg_div),
    .cfg_stop2  (cfg_stop2),
`ifdef UART_PARITY_EN
    .cfg_par_en (cfg_par_en),
    .cfg_par_odd(cfg_par_odd),
    .rx_perr    (rx_perr),
`endif
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_ferr    (rx_ferr),
    .rx_ovf     (rx_ovf),
    .rx_ovf_clr (rx_ovf_clr),
    .tx_busy    (tx_busy),
    .uart_tx    (uart_tx),
    .uart_rx    (uart_rx)
  );

  // Push one word into the TX FIFO; called and returns on a falling edge.
  task automatic push_word(input logic [7:0] d);
    int t = 0;
    while (!tx_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready_timeout got %b want 1", tx_ready);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    $display("tx push %h", d);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Wait for tx_busy to drop within a budget; returns the cycles waited.
  task automatic wait_idle(input int budget, output int waited);
    waited = 0;
    while (tx_busy && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL tx_idle_timeout got %b want 0", tx_busy);
    end
  endtask

  // Drive one serial frame on uart_rx, each bit div+1 clocks.
  task automatic send_rx(input logic [7:0] d, input logic stop_v,
                         input logic par_on, input logic par_v, input int div);
    rx_drv = 1'b0;
    repeat (div + 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      repeat (div + 1) @(negedge clk);
    end
    if (par_on) begin
      rx_drv = par_v;
      repeat (div + 1) @(negedge clk);
    end
    rx_drv = stop_v;
    repeat (div + 1) @(negedge clk);
    rx_drv = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  // Pop the RX head after checking it against the expected word.
  task automatic pop_check(input string tag, input logic [7:0] d, input logic ferr);
    checks++;
    if (rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid got %b want 1", tag, rx_valid);
    end
    checks++;
    if (rx_data !== d) begin
      errors++;
      $display("FAIL %s_data got %h want %h", tag, rx_data, d);
    end
    checks++;
    if (rx_ferr !== ferr) begin
      errors++;
      $display("FAIL %s_ferr got %b want %b", tag, rx_ferr, ferr);
    end
    $display("rx pop %s data=%h ferr=%b", tag, rx_data, rx_ferr);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (uart_tx !== 1'b1)  begin errors++; $display("FAIL reset_uart_tx got %b want 1", uart_tx); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    checks++; if (rx_ovf !== 1'b0)   begin errors++; $display("FAIL reset_rx_ovf got %b want 0", rx_ovf); end
    checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL reset_tx_busy got %b want 0", tx_busy); end
  endtask

  // Capture nbits*10 line samples (cfg_div=9) starting at the first low sample.
  task automatic capture_frame(input logic [7:0] d, input int nbits,
                               output logic [119:0] samp, output logic [119:0] busy);
    int n = 0;
    samp = '1;
    busy = '0;
    push_word(d);
    while (uart_tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL tx_start_latency got %0d want 1", n);
    end
    for (int i = 0; i <= nbits * 10; i++) begin
      samp[i] = uart_tx;
      busy[i] = tx_busy;
      @(negedge clk);
    end
  endtask

  task automatic test_tx_frame();
    logic [119:0] samp, busy;
    logic [9:0]   fr;
    loop = 1'b0;
    cfg_div = 16'd9;
    fr = {1'b1, 8'hA5, 1'b0};
    capture_frame(8'hA5, 10, samp, busy);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (samp[10*k+5] !== fr[k]) begin
        errors++;
        $display("FAIL tx_bit%0d got %b want %b", k, samp[10*k+5], fr[k]);
      end
    end
    checks++; if (samp[9] !== 1'b0)   begin errors++; $display("FAIL tx_start_end got %b want 0", samp[9]); end
    checks++; if (samp[10] !== 1'b1)  begin errors++; $display("FAIL tx_bit0_begin got %b want 1", samp[10]); end
    checks++; if (samp[99] !== 1'b1)  begin errors++; $display("FAIL tx_stop_end got %b want 1", samp[99]); end
    checks++; if (busy[99] !== 1'b1)  begin errors++; $display("FAIL tx_busy_in_stop got %b want 1", busy[99]); end
    checks++; if (busy[100] !== 1'b0) begin errors++; $display("FAIL tx_busy_after got %b want 0", busy[100]); end
  endtask

  task automatic test_loopback();
    int waited;
    loop = 1'b1;
    cfg_div = 16'd15;
    for (int i = 0; i < 8; i++) push_word(8'(i));
    wait_idle(3000, waited);
    // 8 gapless frames of 160 clk starting 1.5 clk after the first push.
    checks++;
    if (waited != 1274) begin
      errors++;
      $display("FAIL tx_gapless_duration got %0d want 1274", waited);
    end
    repeat (40) @(negedge clk);
    for (int i = 0; i < 8; i++) pop_check("loop", 8'(i), 1'b0);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL loop_drained got %b want 0", rx_valid); end
    checks++; if (rx_ovf !== 1'b0)   begin errors++; $display("FAIL loop_ovf got %b want 0", rx_ovf); end
  endtask

  task automatic test_overflow();
    int waited;
    loop = 1'b1;
    cfg_div = 16'd7;
    for (int i = 0; i < 9; i++) push_word(8'h10 + 8'(i));
    wait_idle(3000, waited);
    repeat (30) @(negedge clk);
    checks++; if (rx_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", rx_ovf); end
    for (int i = 0; i < 8; i++) pop_check("ovf", 8'h10 + 8'(i), 1'b0);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovf_ninth_dropped got %b want 0", rx_valid); end
    checks++; if (rx_ovf !== 1'b1)   begin errors++; $display("FAIL ovf_sticky got %b want 1", rx_ovf); end
    rx_ovf_clr = 1'b1;
    @(negedge clk);
    rx_ovf_clr = 1'b0;
    checks++; if (rx_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", rx_ovf); end
  endtask

  task automatic test_ferr();
    loop = 1'b0;
    cfg_div = 16'd15;
    send_rx(8'h3C, 1'b0, 1'b0, 1'b0, 15);
    pop_check("ferr_bad", 8'h3C, 1'b1);
    send_rx(8'h5A, 1'b1, 1'b0, 1'b0, 15);
    pop_check("ferr_good", 8'h5A, 1'b0);
  endtask

  task automatic test_glitch();
    loop = 1'b0;
    cfg_div = 16'd15;
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_no_push got %b want 0", rx_valid); end
    send_rx(8'h81, 1'b1, 1'b0, 1'b0, 15);
    pop_check("after_glitch", 8'h81, 1'b0);
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    loop = 1'b0;
    cfg_div = 16'd9;
    push_word(8'h00);
    while (uart_tx !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (25) @(negedge clk);
    checks++; if (uart_tx !== 1'b0) begin errors++; $display("FAIL midframe_low got %b want 0", uart_tx); end
    rst = 1'b1;
    #1;
    checks++; if (uart_tx !== 1'b1)  begin errors++; $display("FAIL rst_async_tx got %b want 1", uart_tx); end
    checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL rst_busy got %b want 0", tx_busy); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", tx_ready); end
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL post_rst_idle got %b want 1", uart_tx); end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    logic [119:0] samp, busy;
    loop = 1'b0;
    cfg_div = 16'd9;
    cfg_par_en = 1'b1;
    cfg_par_odd = 1'b0;
    capture_frame(8'h07, 11, samp, busy);
    checks++; if (samp[95] !== 1'b1)  begin errors++; $display("FAIL par_bit got %b want 1", samp[95]); end
    checks++; if (samp[105] !== 1'b1) begin errors++; $display("FAIL par_stop got %b want 1", samp[105]); end
    send_rx(8'h07, 1'b1, 1'b1, 1'b0, 9);
    checks++; if (rx_perr !== 1'b1) begin errors++; $display("FAIL perr_bad got %b want 1", rx_perr); end
    pop_check("par_bad", 8'h07, 1'b0);
    send_rx(8'h07, 1'b1, 1'b1, 1'b1, 9);
    checks++; if (rx_perr !== 1'b0) begin errors++; $display("FAIL perr_good got %b want 0", rx_perr); end
    pop_check("par_good", 8'h07, 1'b0);
    cfg_par_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_tx_frame();
    test_loopback();
    test_overflow();
    test_ferr();
    test_glitch();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
